fetch_sequencer: RTL and testbench

//  Instruction-fetch stage sitting directly upstream of the main memory (ram): owns the

---
 rtl/fetch_sequencer.sv | 104 ++++++++++
 tb/tb_fetch_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks IAR through RAM one byte at a time and
// presents each fetched byte in IR to the execute section.
module fetch_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] a,
   output logic              sa,
   output logic              e,
   output logic              s,
   input  logic [DATA_W-1:0] bus,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   input  logic              ir_ack,
   input  logic              jmp_load,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      READ = 2'd2,
      WAIT = 2'd3
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] iar, iar_next;
   logic [DATA_W-1:0] ir_q, ir_next;
   logic              ir_valid_q, ir_valid_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         iar        <= RESET_ADDR;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state      <= state_next;
         iar        <= iar_next;
         ir_q       <= ir_next;
         ir_valid_q <= ir_valid_next;
      end
   end

   // Handshake: a byte is transferred at a rising edge where ir_valid=1 and
   // ir_ack=1; ir stays stable while ir_valid=1, and ir_ack is ignored otherwise.
   always_comb begin
      state_next    = state;
      iar_next      = iar;
      ir_next       = ir_q;
      ir_valid_next = ir_valid_q;

      if (jmp_load) begin
         // A jump abandons any fetch in flight and discards a pending byte.
         iar_next   = jmp_addr;
         state_next = IDLE;
         if (state == WAIT) begin
            ir_valid_next = 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state_next = ADDR;
               end
            end
            ADDR: begin
               state_next = READ;
            end
            READ: begin
               ir_next       = bus;
               iar_next      = iar + 1'b1;
               ir_valid_next = 1'b1;
               state_next    = WAIT;
            end
            WAIT: begin
               if (ir_ack) begin
                  ir_valid_next = 1'b0;
                  state_next    = run ? ADDR : IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign a         = iar;
   assign sa        = (state == ADDR);
   assign e         = (state == READ);
   assign s         = 1'b0;
   assign busy      = (state == ADDR) || (state == READ);
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural RAM, directed fetch/jump/reset vectors,
// and a monitor that checks each presented byte against an expected queue.
module tb_fetch_sequencer;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam logic [1:0] ST_IDLE = 2'd0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run = 1'b0;
   logic [ADDR_W-1:0] a;
   logic              sa, e, s;
   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] ir;
   logic              ir_valid;
   logic              ir_ack = 1'b0;
   logic              jmp_load = 1'b0;
   logic [ADDR_W-1:0] jmp_addr = '0;
   logic              busy;
   logic [1:0]        dbg_state;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mem[256];
   logic [ADDR_W-1:0] mar = '0;

   fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_ADDR(8'h00)) dut (
      .clk(clk), .rst(rst), .run(run), .a(a), .sa(sa), .e(e), .s(s), .bus(bus),
      .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack), .jmp_load(jmp_load),
      .jmp_addr(jmp_addr), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural RAM
   always @(posedge clk) if (sa) mar <= a;
   assign bus = e ? mem[mar] : '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks: inputs change just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic do_jump(input logic [ADDR_W-1:0] target);
      jmp_load = 1'b1;
      jmp_addr = target;
      tick();
      jmp_load = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!ir_valid && n < 10) begin
         tick();
         n++;
      end
      if (!ir_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: ir_valid not seen within 10 cycles", name);
      end
   endtask

   // scoreboard monitor: a new byte is presented when ir_valid rises or
   // follows a consumed byte
   logic prev_valid = 1'b0;
   logic prev_ack = 1'b0;
   always @(negedge clk) begin
      if (ir_valid && (!prev_valid || prev_ack)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL monitor: unexpected byte %0h", ir);
         end else begin
            check("monitor ir", {24'h0, ir}, {24'h0, exp_q.pop_front()});
         end
      end
      prev_valid <= ir_valid;
      prev_ack   <= ir_ack && !rst && !jmp_load;
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // 1 reset
      tick();
      tick();
      @(negedge clk);
      check("rst a", {24'h0, a}, 32'h00);
      check("rst sa", {31'h0, sa}, 32'h0);
      check("rst e", {31'h0, e}, 32'h0);
      check("rst s", {31'h0, s}, 32'h0);
      check("rst busy", {31'h0, busy}, 32'h0);
      check("rst ir_valid", {31'h0, ir_valid}, 32'h0);
      check("rst ir", {24'h0, ir}, 32'h00);
      tick();
      rst = 1'b0;

      // 2 single fetch with latency checks
      mem[8'h00] = 8'hA5;
      exp_q.push_back(8'hA5);
      pulse_run();
      @(negedge clk);
      check("t2 sa N+1", {31'h0, sa}, 32'h1);
      check("t2 e N+1", {31'h0, e}, 32'h0);
      check("t2 busy N+1", {31'h0, busy}, 32'h1);
      tick();
      @(negedge clk);
      check("t2 e N+2", {31'h0, e}, 32'h1);
      check("t2 sa N+2", {31'h0, sa}, 32'h0);
      check("t2 valid N+2", {31'h0, ir_valid}, 32'h0);
      tick();
      @(negedge clk);
      check("t2 valid N+3", {31'h0, ir_valid}, 32'h1);
      check("t2 ir", {24'h0, ir}, 32'hA5);
      check("t2 a", {24'h0, a}, 32'h01);
      check("t2 s", {31'h0, s}, 32'h0);
      tick();
      tick();
      tick();
      @(negedge clk);
      check("t2 hold valid", {31'h0, ir_valid}, 32'h1);
      check("t2 hold ir", {24'h0, ir}, 32'hA5);
      ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;
      @(negedge clk);
      check("t2 ack valid", {31'h0, ir_valid}, 32'h0);
      check("t2 ack idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});

      // 3 streaming, one byte every 3 cycles
      do_jump(8'h00);
      mem[8'h00] = 8'h11;
      mem[8'h01] = 8'h22;
      mem[8'h02] = 8'h33;
      mem[8'h03] = 8'h44;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      run = 1'b1;
      ir_ack = 1'b1;
      n = 0;
      while (!(ir_valid && ir == 8'h44) && n < 40) begin
         tick();
         n++;
      end
      check("t3 cycles to 4th byte", n, 32'd12);
      run = 1'b0;
      tick();
      ir_ack = 1'b0;
      @(negedge clk);
      check("t3 a", {24'h0, a}, 32'h04);
      check("t3 valid", {31'h0, ir_valid}, 32'h0);

      // 4 address wrap
      mem[8'hFF] = 8'h7E;
      exp_q.push_back(8'h7E);
      do_jump(8'hFF);
      pulse_run();
      wait_valid("t4 wait");
      @(negedge clk);
      check("t4 ir", {24'h0, ir}, 32'h7E);
      check("t4 a wrap", {24'h0, a}, 32'h00);
      ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;

      // 5 jump during READ aborts the fetch
      mem[8'h40] = 8'h5C;
      pulse_run();
      tick();
      @(negedge clk);
      check("t5 in READ", {31'h0, e}, 32'h1);
      do_jump(8'h40);
      @(negedge clk);
      check("t5 valid", {31'h0, ir_valid}, 32'h0);
      check("t5 ir kept", {24'h0, ir}, 32'h7E);
      check("t5 idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});
      check("t5 a", {24'h0, a}, 32'h40);
      tick();
      tick();
      @(negedge clk);
      check("t5 still no valid", {31'h0, ir_valid}, 32'h0);
      exp_q.push_back(8'h5C);
      pulse_run();
      wait_valid("t5 wait");
      @(negedge clk);
      check("t5 refetch a", {24'h0, a}, 32'h41);
      ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;

      // 6a jump in WAIT with simultaneous ack flushes the byte
      mem[8'h41] = 8'h9D;
      exp_q.push_back(8'h9D);
      pulse_run();
      wait_valid("t6 wait");
      ir_ack = 1'b1;
      do_jump(8'h20);
      ir_ack = 1'b0;
      @(negedge clk);
      check("t6 flush valid", {31'h0, ir_valid}, 32'h0);
      check("t6 a", {24'h0, a}, 32'h20);
      check("t6 idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});

      // 6b reset during READ
      mem[8'h20] = 8'h3C;
      pulse_run();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("t6 rst s", {31'h0, s}, 32'h0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6 rst idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});
      check("t6 rst a", {24'h0, a}, 32'h00);
      check("t6 rst ir", {24'h0, ir}, 32'h00);
      check("t6 rst valid", {31'h0, ir_valid}, 32'h0);
      tick();
      tick();
      tick();
      @(negedge clk);
      check("t6 rst no valid", {31'h0, ir_valid}, 32'h0);
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
